mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage data access controller. Consumes the execute/memory pipeline register outputs and runs a req/gnt/rvalid handshake to data memory. Performs store byte-lane alignment and load extraction with sign or zero extension. Asserts StallM so the pipeline registers hold until the access completes; ReadDataM feeds the memory/writeback register.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in REQ plus RESP before the access aborts with a bus error
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
rowM  in  1  load request (read) from the execute/memory register
MemwriteM  in  1  store request; wins when rowM is also high
funct3M  in  3  InstrM[14:12], access size and extension
ALUResultM  in  32  byte address
WriteDataM  in  32  store data, unshifted
hold_i  in  1  downstream not advancing; keeps DONE
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  32  word address, {addr[31:2],2'b00}
dmem_wdata  out  32  lane-shifted store data
dmem_be  out  4  byte enables
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load word
ReadDataM  out  32  extended load result
StallM  out  1  hold the pipeline (drives the active-low-stall en of the upstream registers)
MisalignM  out  1  misaligned-access pulse
BusErrM  out  1  illegal-funct3 or timeout pulse

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access): state IDLE; dmem_req, dmem_we, dmem_be, StallM, MisalignM and BusErrM are 0; dmem_addr, dmem_wdata and ReadDataM are 0; counter is 0.
- access = rowM | MemwriteM.
- States IDLE, REQ, RESP, DONE.
- IDLE, access=1: latch address, wdata, be, funct3 and we into internal registers.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go DONE with MisalignM=1 and no request.
  - Illegal funct3 (load 011/110/111, store other than 000/001/010): go DONE with BusErrM=1 and no request.
  - Otherwise go REQ.
- REQ: dmem_req=1 with all outputs driven from the latched registers, held stable until dmem_gnt. On gnt: store goes DONE; load goes RESP.
- RESP: wait for dmem_rvalid. Capture the extracted, extended data into ReadDataM, then go DONE.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYCLES: dmem_req drops, go DONE, BusErrM=1, ReadDataM=0.
- DONE: StallM=0. Flags and ReadDataM hold while hold_i=1; when hold_i=0, go IDLE. MisalignM and BusErrM are registered, high only in DONE, and clear on DONE exit.
- StallM is combinational: (IDLE & access) | REQ | RESP. It rises in the same cycle a new access appears.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111.
  - Loads drive be = 1111.
- Load extract:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
- Minimum latency with gnt on the first REQ cycle and rvalid on the first RESP cycle:
  - Load: IDLE, REQ, RESP, DONE; 3 stall cycles.
  - Store: IDLE, REQ, DONE; 2 stall cycles.
- dmem_rvalid outside RESP and dmem_gnt outside REQ are ignored.
- rdata sampled only when rvalid is high; ALU-only instructions (access=0) never stall.

Decomposition:
- Shared package riscv_pkg: funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
- Sub-module load_extend: combinational extraction and extension from rdata, addr[1:0] and funct3.

Test Plan:
- LW addr 0x100, gnt in REQ cycle 1, rvalid 1 cycle later with rdata 0xDEADBEEF -> StallM high 3 cycles, ReadDataM=0xDEADBEEF in DONE, dmem_addr=0x100.
- LB addr 0x103, rdata 0x80FF_0000 -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH addr 0x202, WriteDataM 0x1234ABCD, gnt delayed 3 cycles -> dmem_be=1100, dmem_wdata=0xABCDABCD held stable through 4 REQ cycles, then DONE.
- LW addr 0x101 -> no dmem_req, MisalignM=1 in DONE, StallM high for 1 cycle.
- Load with no rvalid, TIMEOUT_CYCLES=16 -> dmem_req drops after gnt, BusErrM=1, ReadDataM=0, state IDLE after DONE with hold_i=0.
- Reset asserted in RESP -> dmem_req and StallM go 0 immediately; a subsequent SW with gnt in the first REQ cycle completes in 3 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory-stage access path: funct3 load/store codes,
// the access FSM states and small decode helpers.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    if (is_store) return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

  // funct3[1:0] is the access size for both loads and stores.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) & off[0]) | ((f3[1:0] == 2'b10) & (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a load word and sign/zero extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data access controller: req/gnt/rvalid handshake to data memory,
// store lane alignment, load extension and pipeline stall generation.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rowM,
  input  logic        MemwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        hold_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);
  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              buserr_q, buserr_d;

  logic              access;
  logic [CNT_W-1:0]  cnt_inc;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  load_extend u_load_extend (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  assign access  = rowM | MemwriteM;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = WriteDataM;
    if (MemwriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << ALUResultM[1:0];
          lane_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          lane_be    = 4'b0011 << ALUResultM[1:0];
          lane_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    buserr_d   = buserr_q;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          addr_d   = ALUResultM;
          wdata_d  = lane_wdata;
          be_d     = lane_be;
          funct3_d = funct3M;
          we_d     = MemwriteM;
          cnt_d    = '0;
          rdata_d  = 32'd0;
          if (f3_illegal(funct3M, MemwriteM)) begin
            buserr_d = 1'b1;
            state_d  = ST_DONE;
          end else if (f3_misaligned(funct3M, ALUResultM[1:0])) begin
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (dmem_gnt) begin
          state_d = we_q ? ST_DONE : ST_RESP;
        end else if (cnt_inc == TMO) begin
          buserr_d = 1'b1;
          rdata_d  = 32'd0;
          state_d  = ST_DONE;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_inc;
        if (dmem_rvalid) begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end else if (cnt_inc == TMO) begin
          buserr_d = 1'b1;
          rdata_d  = 32'd0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!hold_i) begin
          misalign_d = 1'b0;
          buserr_d   = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  // Bus outputs come only from latched registers so they stay stable while waiting for gnt.
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign ReadDataM  = rdata_q;
  assign MisalignM  = misalign_q;
  assign BusErrM    = buserr_q;
  assign StallM     = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ) | (state_q == ST_RESP);

endmodule
